// File: rtl/calc_operand_alu_pkg.sv
// Shared constants for the operand ALU: opcodes, FSM encoding, default widths and the largest
// representable decimal magnitude.
package calc_pkg;
  localparam int DEF_DIGITS = 10;
  localparam int DEF_BIN_W  = 34;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_IN,
    S_EXEC,
    S_MUL,
    S_CONV_OUT,
    S_DONE
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DEF_DIGITS) - 64'd1;
endpackage

// File: rtl/calc_operand_alu_if.sv
// Entry-buffer, command-pulse and result bundle between the calculator front end and the ALU.
// The ALU takes the slave side; pulses arriving while busy is high are dropped.
interface calc_operand_alu_if #(
  parameter int DIGITS = calc_pkg::DEF_DIGITS
);
  logic [4*DIGITS-1:0] numActual;
  logic [3:0]          counterTotal;
  logic                saveNumber;
  logic                opValid;
  logic [1:0]          opCode;
  logic                evaluate;
  logic [4*DIGITS-1:0] result;
  logic [3:0]          resultDigits;
  logic                negative;
  logic                overflow;
  logic                busy;
  logic                resultValid;

  modport master (
    output numActual, counterTotal, saveNumber, opValid, opCode, evaluate,
    input  result, resultDigits, negative, overflow, busy, resultValid
  );

  modport slave (
    input  numActual, counterTotal, saveNumber, opValid, opCode, evaluate,
    output result, resultDigits, negative, overflow, busy, resultValid
  );
endinterface

// File: rtl/calc_operand_alu_bin2bcd_dabble.sv
// Sequential double-dabble binary->BCD converter; done pulses BIN_W+1 cycles after start.
// start is only accepted while idle and is otherwise ignored.
module bin2bcd_dabble
  import calc_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [BIN_W-1:0]    i_bin,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd
);
  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_bin  <= i_bin;
          r_bcd  <= '0;
          r_cnt  <= CW'(BIN_W);
          r_busy <= 1'b1;
        end
      end else begin
        r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/calc_operand_alu.sv
// Two-operand BCD calculator core: BCD->bin capture, ADD/SUB (1 cycle) or shift-add MUL (BIN_W cycles),
// then double-dabble back to BCD; worst-case evaluate latency ~2*BIN_W+2 cycles, pulses dropped while busy.
module calc_operand_alu
  import calc_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic              CLK_100MHZ,
  input  logic              reset,
  calc_operand_alu_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = 2 * BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [PW-1:0] L_MAX = PW'(pow10(DIGITS) - 64'd1);

  state_t           r_state;
  logic [W-1:0]     r_entry;
  logic [BIN_W-1:0] r_acc, r_a, r_b, r_res, r_mplier;
  logic             r_a_vld, r_b_vld;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_mcand, r_prod;
  logic             r_neg_pend, r_conv_start;
  logic [W-1:0]     r_result;
  logic [3:0]       r_digits;
  logic             r_neg, r_ovf;

  logic [3:0]       w_n, w_digit, w_ndig;
  logic [BIN_W-1:0] w_acc_next;
  logic [BIN_W:0]   w_sum;
  logic [PW-1:0]    w_prod_next;
  logic             w_conv_done;
  logic [W-1:0]     w_bcd;

  // Entry is pre-shifted so the most significant valid digit sits in the top nibble.
  always_comb begin
    w_n         = (int'(bus.counterTotal) > DIGITS) ? 4'(DIGITS) : bus.counterTotal;
    w_digit     = (r_entry[W-1 -: 4] > 4'd9) ? 4'd9 : r_entry[W-1 -: 4];
    w_acc_next  = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_digit);
    w_sum       = {1'b0, r_a} + {1'b0, r_b};
    w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    w_ndig      = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_bcd[4*i +: 4] != 4'd0) w_ndig = 4'(i + 1);
    end
  end

  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_entry      <= '0;
      r_acc        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_mplier     <= '0;
      r_a_vld      <= 1'b0;
      r_b_vld      <= 1'b0;
      r_op         <= OP_ADD;
      r_cnt        <= '0;
      r_mcand      <= '0;
      r_prod       <= '0;
      r_neg_pend   <= 1'b0;
      r_conv_start <= 1'b0;
      r_result     <= '0;
      r_digits     <= 4'd1;
      r_neg        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.saveNumber) begin
            r_entry <= bus.numActual << (4 * (DIGITS - int'(w_n)));
            r_acc   <= '0;
            r_cnt   <= (w_n == 4'd0) ? CW'(1) : CW'(w_n);
            r_state <= S_CONV_IN;
          end else if (bus.evaluate) begin
            if (r_a_vld && r_b_vld) begin
              if (r_op == OP_MUL) begin
                r_mcand  <= PW'(r_a);
                r_mplier <= r_b;
                r_prod   <= '0;
                r_cnt    <= CW'(BIN_W);
                r_state  <= S_MUL;
              end else begin
                r_state <= S_EXEC;
              end
            end else if (r_a_vld) begin
              r_res        <= r_a;
              r_neg_pend   <= 1'b0;
              r_conv_start <= 1'b1;
              r_state      <= S_CONV_OUT;
            end
          end else if (bus.opValid) begin
            r_op <= bus.opCode;
          end
        end
        S_CONV_IN: begin
          r_acc   <= w_acc_next;
          r_entry <= r_entry << 4;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (!r_a_vld) begin
              r_a     <= w_acc_next;
              r_a_vld <= 1'b1;
            end else begin
              r_b     <= w_acc_next;
              r_b_vld <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (r_op == OP_SUB) begin
            r_neg_pend   <= (r_a < r_b);
            r_res        <= (r_a < r_b) ? (r_b - r_a) : (r_a - r_b);
            r_conv_start <= 1'b1;
            r_state      <= S_CONV_OUT;
          end else if (PW'(w_sum) > L_MAX) begin
            r_result <= '0;
            r_digits <= 4'd1;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_neg_pend   <= 1'b0;
            r_res        <= w_sum[BIN_W-1:0];
            r_conv_start <= 1'b1;
            r_state      <= S_CONV_OUT;
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (w_prod_next > L_MAX) begin
              r_result <= '0;
              r_digits <= 4'd1;
              r_neg    <= 1'b0;
              r_ovf    <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_neg_pend   <= 1'b0;
              r_res        <= w_prod_next[BIN_W-1:0];
              r_conv_start <= 1'b1;
              r_state      <= S_CONV_OUT;
            end
          end
        end
        S_CONV_OUT: begin
          if (w_conv_done) begin
            r_result <= w_bcd;
            r_digits <= w_ndig;
            r_neg    <= r_neg_pend;
            r_ovf    <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_a_vld <= 1'b0;
          r_b_vld <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  bin2bcd_dabble #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) u_dabble (
    .clk    (CLK_100MHZ),
    .rst    (reset),
    .i_start(r_conv_start),
    .i_bin  (r_res),
    .o_done (w_conv_done),
    .o_bcd  (w_bcd)
  );

  assign bus.result       = r_result;
  assign bus.resultDigits = r_digits;
  assign bus.negative     = r_neg;
  assign bus.overflow     = r_ovf;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.resultValid  = (r_state == S_DONE);
endmodule

// File: doc/calc_operand_alu.md
Name: calc_operand_alu

Overview:
- Execution stage directly downstream of NumberMemory and StateMachineCalculator; consumes the BCD entry buffer (numActual/counterTotal) on each save pulse.
- Holds two operands and the selected operator.
- Computes ADD/SUB/MUL with sequential units and returns a signed BCD result for the VGA painter to display.
- Converts BCD->binary on capture and binary->BCD on output.

Parameters:
- DIGITS, 10, BCD digits per operand/result (numActual width = 4*DIGITS)
- BIN_W, 34, binary datapath width (ceil(log2(10^DIGITS)))

Ports:
- CLK_100MHZ  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- numActual  in  4*DIGITS  entry buffer; digit i = bits [4i+3:4i], digit 0 least significant
- counterTotal  in  4  number of valid digits, 0..DIGITS; values >DIGITS treated as DIGITS
- saveNumber  in  1  one-cycle pulse (guardeNum): capture current entry as next operand
- opValid  in  1  one-cycle pulse: latch opCode
- opCode  in  2  0=ADD, 1=SUB, 2=MUL, 3=reserved (treated as ADD)
- evaluate  in  1  one-cycle pulse (leaResult): compute result
- result  out  4*DIGITS  BCD magnitude of last result, same digit order as numActual
- resultDigits  out  4  significant digits in result (1..DIGITS; 1 for zero)
- negative  out  1  result sign
- overflow  out  1  magnitude exceeded 10^DIGITS-1
- busy  out  1  FSM not in IDLE
- resultValid  out  1  one-cycle pulse when result/flags update

Behaviour:
- Reset values (async, immediate): result=0, resultDigits=1, negative=0, overflow=0, busy=0, resultValid=0, opcode=ADD, both operand slots empty, FSM=IDLE.
- FSM states:
  - IDLE
  - CONV_IN: BCD->bin, one digit per cycle
  - EXEC: ADD/SUB, 1 cycle
  - MUL: shift-add, BIN_W cycles
  - CONV_OUT: double-dabble, BIN_W cycles
  - DONE: 1 cycle, pulses resultValid
- IDLE behaviour:
  - saveNumber -> CONV_IN. Accumulator is built from digit counterTotal-1 down to 0 as acc = acc*10 + d. Digits >9 are saturated to 9. Digits above counterTotal are ignored.
  - When conversion finishes, the value goes to slot A if A is empty, else to slot B (an existing B is overwritten). Return to IDLE.
  - Latency: max(counterTotal,1)+1 cycles. counterTotal=0 stores 0.
- opValid: latched only in IDLE; last pulse wins.
- evaluate in IDLE:
  - A and B both valid -> EXEC (ADD/SUB) or MUL.
  - Only A valid -> result = A (pass-through via CONV_OUT).
  - Neither valid -> ignored, no resultValid.
- SUB: if A<B then negative=1 and magnitude = B-A; otherwise negative=0.
- MUL: 2*BIN_W-bit product. overflow=1 if the product >= 10^DIGITS.
- ADD: overflow=1 if the sum >= 10^DIGITS.
- On overflow: result=0, resultDigits=1, negative=0, and CONV_OUT is skipped.
- CONV_OUT: BIN_W shift cycles with add-3 per nibble; resultDigits = index of the highest nonzero digit + 1.
- DONE: outputs update and resultValid=1 for exactly this cycle. Operand slots are then cleared and the opcode is kept. Outputs hold until the next DONE or reset.
- Simultaneous events in IDLE: priority saveNumber > evaluate > opValid; lower-priority pulses in the same cycle are dropped.
- Any pulse while busy=1 is dropped (no queueing).
- Reset mid-operation aborts immediately; no resultValid follows.
- Worst-case evaluate latency: MUL = 1 + BIN_W + BIN_W + 1 = 70 cycles.

Decomposition:
- Package calc_pkg holds:
  - opcode localparams OP_ADD/OP_SUB/OP_MUL
  - FSM state encoding
  - DIGITS and BIN_W defaults
  - constant MAX_VAL = 10^DIGITS-1
- One sub-module: bin2bcd_dabble. It is the sequential double-dabble converter with start/done handshake. start is accepted only when idle, and done is a one-cycle pulse BIN_W+1 cycles after start.
- BCD->bin and the multiplier stay inline.

Test Plan:
- Add: save "12" (counterTotal=2), opValid ADD, save "7", evaluate -> after DONE result=0x19, resultDigits=2, negative=0, overflow=0, resultValid high exactly 1 cycle.
- Subtract: save 5, SUB, save 12, evaluate -> result=0x7, negative=1, resultDigits=1.
- Multiply: 99999*100000 -> result=0x9999900000, resultDigits=10. Then 100000*100000 -> overflow=1, result=0, resultDigits=1.
- Busy/priority:
  - evaluate and opValid pulsed during MUL -> ignored, single resultValid.
  - saveNumber+evaluate in the same IDLE cycle -> only capture occurs.
- Masking and edge digits:
  - numActual=0x00000FF123 with counterTotal=3 -> operand 123, pass-through evaluate gives result=0x123.
  - counterTotal=0 -> operand 0.
- Reset mid-MUL: assert reset at cycle 20 of MUL -> all outputs at reset values asynchronously, busy=0, no resultValid afterwards, slots empty.
